// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus start/busy handshake in front of the UART TX.
// Define UART_TX_FEEDER_STATS_EN to add tx_done_count and drop_count.
module uart_tx_feeder #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    input  logic [7:0]      s_data,
    output logic            s_ready,
    input  logic            flush,
    output logic            tx_start,
    output logic [7:0]      tx_data,
    input  logic            tx_busy,
    output logic [ADDR_W:0] fifo_count,
    output logic            fifo_empty,
    output logic            fifo_full,
    output logic            timeout_err
`ifdef UART_TX_FEEDER_STATS_EN
    ,
    output logic [15:0]     tx_done_count,
    output logic [7:0]      drop_count
`endif
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [TW-1:0]   TMO      = TW'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              timeout_err_q, timeout_err_d;
    logic [7:0]        mem_q [DEPTH];
    logic              push;
    logic              pop;

    assign fifo_full   = (count_q == FULL_CNT);
    assign fifo_empty  = (count_q == '0);
    assign fifo_count  = count_q;
    assign s_ready     = rst_n && !fifo_full && !flush;
    assign push        = s_valid && s_ready;
    assign pop         = (state_q == IDLE) && !fifo_empty;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign timeout_err = timeout_err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        // A pop in the flush cycle still loads tx_data below.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    tx_data_d  = mem_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                tmo_cnt_d = '0;
                // Busy already high here counts as the hand-off.
                state_d   = tx_busy ? WAIT_DONE : WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                    if (tmo_cnt_d == TMO) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tmo_cnt_q     <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tmo_cnt_q     <= tmo_cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

`ifdef UART_TX_FEEDER_STATS_EN
    logic [15:0] done_cnt_q, done_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    assign tx_done_count = done_cnt_q;
    assign drop_count    = drop_cnt_q;

    always_comb begin
        done_cnt_d = done_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (state_q == WAIT_DONE && !tx_busy) begin
            done_cnt_d = done_cnt_q + 16'd1;
        end
        if (s_valid && fifo_full && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end
`endif

endmodule
